aes_128_top: RTL and testbench



---
 rtl/aes_pkg.sv | 92 +++++++++
 rtl/aes128_core.sv | 107 ++++++++++
 rtl/aes_128_top.sv | 22 ++
 tb/tb_aes_128_top.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and the byte/word transforms used by the core.
// Byte 0 of a block sits in bits 127..120; bytes fill the 4x4 state column by column.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [1:0] {
        KEY_EXP = 2'd0,
        IDLE    = 2'd1,
        RUN     = 2'd2
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]), mix_column(s[31:0])};
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127 - 8*i -: 8] = SBOX[s[127 - 8*i -: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes128_core.sv
// Iterative AES-128 encryptor: one-shot key expansion after reset, then one round per clock.
// KEY_EXP | writing round keys 0..10 | IDLE | waiting for start | RUN | applying rounds 1..10
module aes128_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         done
);

    aes_state_e   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;
    logic         key_ready_q, key_ready_d;
    logic         key_ready;

    logic [127:0] rk_q [0:10];
    logic         rk_we;
    logic [3:0]   rk_idx;
    logic [127:0] rk_wdata;

    logic [127:0] sr_out;
    logic [127:0] round_out;

    assign sr_out    = shift_rows(sub_bytes(blk_q));
    assign round_out = rk_q[round_q] ^ ((round_q == NR) ? sr_out : mix_columns(sr_out));

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        blk_d       = blk_q;
        ct_d        = ct_q;
        done_d      = 1'b0;
        key_ready_d = key_ready_q;
        rk_we       = 1'b0;
        rk_idx      = round_q;
        rk_wdata    = key;
        case (state_q)
            KEY_EXP: begin
                // round_q doubles as the index of the round key being written
                rk_we   = 1'b1;
                round_d = round_q + 4'd1;
                if (round_q != 4'd0) begin
                    rk_wdata = key_step(rk_q[round_q - 4'd1], RCON[round_q - 4'd1]);
                end
                if (round_q == NR) begin
                    key_ready_d = 1'b1;
                    round_d     = 4'd0;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (start) begin
                    blk_d   = plaintext ^ rk_q[0];
                    round_d = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                blk_d   = round_out;
                round_d = round_q + 4'd1;
                if (round_q == NR) begin
                    ct_d    = round_out;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = KEY_EXP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= KEY_EXP;
            round_q     <= 4'd0;
            blk_q       <= '0;
            ct_q        <= '0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            blk_q       <= blk_d;
            ct_q        <= ct_d;
            done_q      <= done_d;
            key_ready_q <= key_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rk_we && !reset) begin
            rk_q[rk_idx] <= rk_wdata;
        end
    end

    assign key_ready  = key_ready_q;
    assign ciphertext = ct_q;
    assign done       = done_q;

endmodule

// File: rtl/aes_128_top.sv
// AES-128 encrypt-only engine; a thin wrapper around the iterative core.
module aes_128_top (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         done
);

    aes128_core CORE (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .ciphertext (ciphertext),
        .done       (done)
    );

endmodule

// File: tb/tb_aes_128_top.sv
// Bench for aes_128_top: FIPS-197 vectors plus random back-to-back blocks against a byte-level AES model.
module tb_aes_128_top;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic [127:0] ciphertext;
    logic         done;

    int           n_checks = 0;
    int           n_err = 0;
    logic [127:0] cur_key;
    logic [127:0] last_ct;
    logic [7:0]   ref_sbox [256];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_128_top dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .ciphertext (ciphertext),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box built from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            ref_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   st [4][4];
        logic [7:0]   tmp [4][4];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]], ref_sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127 - 8*(r + 4*c) -: 8] ^ w[c][31 - 8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    tmp[r][c] = ref_sbox[st[r][(c + r) % 4]];
            st = tmp;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        tmp[r][c] = gmul(8'h02, st[r][c]) ^ gmul(8'h03, st[(r+1)%4][c])
                                  ^ st[(r+2)%4][c] ^ st[(r+3)%4][c];
                st = tmp;
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    st[r][c] = st[r][c] ^ w[4*rnd + c][31 - 8*r -: 8];
        end
        out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127 - 8*(r + 4*c) -: 8] = st[r][c];
        return out;
    endfunction

    // Reset for 4 cycles, then watch key expansion; start is pulsed at edge 'poke' (0 = never).
    task automatic reset_expand(input logic [127:0] k, input int poke);
        reset = 1'b1;
        start = 1'b0;
        key = k;
        cur_key = k;
        last_ct = '0;
        repeat (4) tick();
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_ct", ciphertext, '0);
        check("rst_key_ready", 128'(dut.CORE.key_ready), 128'(1'b0));
        reset = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            start = (e == poke);
            plaintext = rand128();
            tick();
            start = 1'b0;
            check("key_ready", 128'(dut.CORE.key_ready), 128'(e == 11));
            check("exp_done", 128'(done), 128'(1'b0));
            check("exp_ct", ciphertext, '0);
        end
        key = rand128();
    endtask

    // One block; start re-pulsed before round edge 'poke' (0 = never) must be ignored.
    task automatic encrypt(input logic [127:0] pt, input logic [127:0] exp, input string tag, input int poke);
        plaintext = pt;
        start = 1'b1;
        tick();
        start = 1'b0;
        plaintext = rand128();
        for (int i = 1; i <= 10; i++) begin
            start = (i == poke);
            tick();
            start = 1'b0;
            check({tag, "_done"}, 128'(done), 128'(i == 10));
            if (i < 10) check({tag, "_ct_hold"}, ciphertext, last_ct);
        end
        check(tag, ciphertext, exp);
        last_ct = exp;
        for (int i = 0; i < 2; i++) begin
            tick();
            check({tag, "_done_low"}, 128'(done), 128'(1'b0));
            check({tag, "_ct_after"}, ciphertext, exp);
        end
    endtask

    initial begin
        logic [127:0] hist [$];
        int           n_done;
        int           edge_n;
        int           extra;

        build_sbox();

        reset_expand(K1, 0);
        encrypt(P1, C1, "fips_c1", 0);

        reset_expand(K2, 0);
        check("rk10", dut.CORE.rk_q[10], R10);
        encrypt(P2, C2, "fips_b", 0);

        reset_expand('0, 0);
        encrypt('0, C0, "zero", 0);

        reset_expand(K2, 3);
        encrypt(P2, C2, "ignored_start", 5);

        plaintext = rand128();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_done", 128'(done), 128'(1'b0));
            check("abort_ct", ciphertext, '0);
        end

        reset_expand(rand128(), 0);
        n_done = 0;
        edge_n = 0;
        start = 1'b1;
        for (int cyc = 0; cyc < 1024*11 + 40 && n_done < 1024; cyc++) begin
            plaintext = rand128();
            hist.push_back(plaintext);
            tick();
            if (done) begin
                check("b2b_edge", 128'(edge_n), 128'(10 + 11*n_done));
                if (edge_n >= 10) check("b2b_ct", ciphertext, ref_encrypt(cur_key, hist[edge_n - 10]));
                n_done++;
                if (n_done == 1024) start = 1'b0;
            end
            edge_n++;
        end
        start = 1'b0;
        check("b2b_count", 128'(n_done), 128'(1024));
        extra = 0;
        repeat (15) begin
            tick();
            if (done) extra++;
        end
        check("b2b_extra_done", 128'(extra), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
